// File: rtl/instr_pack.sv
// Shared definitions for the 9-bit CPU ALU issue path.
//   math_t        : 4-bit ALU math operation encoding
//   issue_state_t : issue controller states
//   OPC_*         : field positions inside the 9-bit instruction word
package instr_pack;

    localparam int unsigned NREG         = 8;
    localparam int unsigned HOLD_MAX_DEF = 15;

    localparam int unsigned OPC_ALU_BIT  = 8;
    localparam int unsigned OPC_MATH_MSB = 7;
    localparam int unsigned OPC_MATH_LSB = 4;
    localparam int unsigned OPC_RS_BIT   = 3;

    typedef enum logic [3:0] {
        AMP  = 4'd0,
        LOR  = 4'd1,
        FLP  = 4'd2,
        EOR  = 4'd3,
        RSC  = 4'd4,
        LSC  = 4'd5,
        ROL  = 4'd6,
        ROR  = 4'd7,
        ADD  = 4'd8,
        SUB  = 4'd9,
        EQL8 = 4'd10,
        EQL5 = 4'd11,
        REVx = 4'd12,
        REVy = 4'd13,
        PARx = 4'd14,
        PARy = 4'd15
    } math_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } issue_state_t;

endpackage

// File: rtl/alu_issue_if.sv
// Bus bundle between the ALU issue controller and its environment
// (fetch, register file, ALU, writeback).
//   master : issue controller side
//   slave  : environment side
// Optional ALU_ISSUE_FLAGS_EN adds zero_flag / neg_flag.
interface alu_issue_if;
    logic [8:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] acc;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [3:0] alu_op;
    logic       alu_en;
    logic       alu_rs;
    logic [7:0] r_in;
    logic [7:0] s_in;
    logic [7:0] wb_data;
    logic       wb_dest;
    logic       wb_valid;
    logic       wb_ready;
    logic       bypass_valid;
    logic [7:0] bypass_instr;
    logic       wb_timeout;
`ifdef ALU_ISSUE_FLAGS_EN
    logic       zero_flag;
    logic       neg_flag;

    modport master (
        input  instr, instr_valid, acc, rd_data, r_in, s_in, wb_ready,
        output instr_ready, rd_addr, alu_x, alu_y, alu_op, alu_en, alu_rs,
               wb_data, wb_dest, wb_valid, bypass_valid, bypass_instr, wb_timeout,
               zero_flag, neg_flag
    );
    modport slave (
        output instr, instr_valid, acc, rd_data, r_in, s_in, wb_ready,
        input  instr_ready, rd_addr, alu_x, alu_y, alu_op, alu_en, alu_rs,
               wb_data, wb_dest, wb_valid, bypass_valid, bypass_instr, wb_timeout,
               zero_flag, neg_flag
    );
`else
    modport master (
        input  instr, instr_valid, acc, rd_data, r_in, s_in, wb_ready,
        output instr_ready, rd_addr, alu_x, alu_y, alu_op, alu_en, alu_rs,
               wb_data, wb_dest, wb_valid, bypass_valid, bypass_instr, wb_timeout
    );
    modport slave (
        output instr, instr_valid, acc, rd_data, r_in, s_in, wb_ready,
        input  instr_ready, rd_addr, alu_x, alu_y, alu_op, alu_en, alu_rs,
               wb_data, wb_dest, wb_valid, bypass_valid, bypass_instr, wb_timeout
    );
`endif
endinterface

// File: rtl/issue_decode.sv
// Combinational field split of a 9-bit instruction word.
//   instr  : instruction word
//   is_alu : ALU-class instruction
//   op     : math operation
//   rs     : destination select (0 = r, 1 = s)
//   raddr  : y operand register index
module issue_decode
    import instr_pack::*;
(
    input  logic [8:0] instr,
    output logic       is_alu,
    output math_t      op,
    output logic       rs,
    output logic [2:0] raddr
);
    assign is_alu = instr[OPC_ALU_BIT];
    assign op     = math_t'(instr[OPC_MATH_MSB:OPC_MATH_LSB]);
    assign rs     = instr[OPC_RS_BIT];
    assign raddr  = instr[2:0];
endmodule

// File: rtl/alu_issue.sv
// Issue-side controller for the 8-bit ALU: accepts ALU instructions, drives
// the ALU for one cycle, captures r/s result and hands it to writeback.
// Non-ALU instructions leave on a one-cycle bypass strobe.
//   clk, reset : clock, synchronous active-high reset
//   bus        : alu_issue_if.master (fetch, regfile, ALU and writeback signals)
// Optional macro ALU_ISSUE_FLAGS_EN adds registered zero_flag / neg_flag.
module alu_issue
    import instr_pack::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    alu_issue_if.master bus
);
    localparam int unsigned CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_PRE = CW'(HOLD_MAX - 1);

    issue_state_t state_q, state_d;

    logic       is_alu;
    math_t      dec_op;
    logic       dec_rs;
    logic [2:0] dec_raddr;

    logic          accept, bypass_take, stall;
    logic [7:0]    result;
    logic [7:0]    alu_x_q, alu_y_q;
    math_t         alu_op_q;
    logic          alu_rs_q;
    logic [2:0]    raddr_q;
    logic [7:0]    wb_data_q;
    logic          wb_dest_q;
    logic          bypass_valid_q;
    logic [7:0]    bypass_instr_q;
    logic          wb_timeout_q;
    logic [CW-1:0] hold_cnt_q;

    issue_decode u_decode (
        .instr  (bus.instr),
        .is_alu (is_alu),
        .op     (dec_op),
        .rs     (dec_rs),
        .raddr  (dec_raddr)
    );

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        bypass_take = 1'b0;
        stall       = 1'b0;
        case (state_q)
            IDLE: begin
                accept      = bus.instr_valid && is_alu;
                bypass_take = bus.instr_valid && !is_alu;
                if (accept) state_d = ISSUE;
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD: begin
                stall = !bus.wb_ready;
                if (bus.wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The ALU latched its result on the enable cycle; pick the written side.
    assign result = alu_rs_q ? bus.s_in : bus.r_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            alu_x_q        <= '0;
            alu_y_q        <= '0;
            alu_op_q       <= AMP;
            alu_rs_q       <= 1'b0;
            raddr_q        <= '0;
            wb_data_q      <= '0;
            wb_dest_q      <= 1'b0;
            bypass_valid_q <= 1'b0;
            bypass_instr_q <= '0;
            wb_timeout_q   <= 1'b0;
            hold_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            bypass_valid_q <= bypass_take;
            // Fires only on the stall that brings the counter up to the limit.
            wb_timeout_q   <= stall && (hold_cnt_q == HOLD_PRE);
            if (accept) begin
                alu_x_q  <= bus.acc;
                alu_y_q  <= bus.rd_data;
                alu_op_q <= dec_op;
                alu_rs_q <= dec_rs;
                raddr_q  <= dec_raddr;
            end
            if (bypass_take) bypass_instr_q <= bus.instr[7:0];
            if (state_q == CAPTURE) begin
                wb_data_q <= result;
                wb_dest_q <= alu_rs_q;
            end
            if (stall) begin
                if (hold_cnt_q != HOLD_LIM) hold_cnt_q <= hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_q <= '0;
            end
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic zero_flag_q, neg_flag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_flag_q <= 1'b0;
            neg_flag_q  <= 1'b0;
        end else if (state_q == CAPTURE) begin
            zero_flag_q <= (result == 8'h00);
            neg_flag_q  <= result[7];
        end
    end

    assign bus.zero_flag = zero_flag_q;
    assign bus.neg_flag  = neg_flag_q;
`endif

    assign bus.instr_ready  = (state_q == IDLE);
    assign bus.rd_addr      = (state_q == IDLE) ? dec_raddr : raddr_q;
    assign bus.alu_x        = alu_x_q;
    assign bus.alu_y        = alu_y_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.alu_en       = (state_q == ISSUE);
    assign bus.alu_rs       = alu_rs_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_dest      = wb_dest_q;
    assign bus.wb_valid     = (state_q == HOLD);
    assign bus.bypass_valid = bypass_valid_q;
    assign bus.bypass_instr = bypass_instr_q;
    assign bus.wb_timeout   = wb_timeout_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with a small register file and
// an ALU model that updates r or s only on alu_en.
module tb_alu_issue;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_issue_if bus ();

    alu_issue #(
        .HOLD_MAX (15)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rf [8];
    logic [7:0] alu_r = 8'h00;
    logic [7:0] alu_s = 8'h00;
    logic [7:0] alu_res;

    assign bus.rd_data = rf[bus.rd_addr];
    assign bus.r_in    = alu_r;
    assign bus.s_in    = alu_s;

    always_comb begin
        alu_res = bus.alu_x;
        case (bus.alu_op)
            4'd0:    alu_res = bus.alu_x & bus.alu_y;
            4'd3:    alu_res = bus.alu_x ^ bus.alu_y;
            4'd8:    alu_res = bus.alu_x + bus.alu_y;
            4'd9:    alu_res = bus.alu_x - bus.alu_y;
            4'd10:   alu_res = (bus.alu_x == bus.alu_y) ? 8'h01 : 8'h00;
            default: alu_res = bus.alu_x;
        endcase
    end

    always @(posedge clk) begin
        if (bus.alu_en) begin
            if (bus.alu_rs) alu_s <= alu_res;
            else            alu_r <= alu_res;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts just after a negedge; returns at the negedge of the first HOLD
    // cycle (rdy = 0) or of the cycle after writeback (rdy = 1).
    task automatic run_alu(input logic [8:0] ins, input logic [7:0] a, input logic [7:0] yv,
                           input logic rdy, input logic [7:0] exp_data);
        rf[ins[2:0]]    = yv;
        bus.acc         = a;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        bus.wb_ready    = rdy;
        #1;
        check("c0_rd_addr", 32'(bus.rd_addr), 32'(ins[2:0]));
        check("c0_ready", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("c1_alu_en", 32'(bus.alu_en), 32'd1);
        check("c1_alu_op", 32'(bus.alu_op), 32'(ins[7:4]));
        check("c1_alu_rs", 32'(bus.alu_rs), 32'(ins[3]));
        check("c1_alu_x", 32'(bus.alu_x), 32'(a));
        check("c1_alu_y", 32'(bus.alu_y), 32'(yv));
        check("c1_ready", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        check("c2_alu_en", 32'(bus.alu_en), 32'd0);
        check("c2_wb_valid", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        check("c3_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("c3_wb_data", 32'(bus.wb_data), 32'(exp_data));
        check("c3_wb_dest", 32'(bus.wb_dest), 32'(ins[3]));
        check("c3_alu_en", 32'(bus.alu_en), 32'd0);
        if (rdy) begin
            @(negedge clk);
            check("c4_wb_valid", 32'(bus.wb_valid), 32'd0);
            check("c4_ready", 32'(bus.instr_ready), 32'd1);
            check("c4_timeout", 32'(bus.wb_timeout), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        reset           = 1'b1;
        bus.instr       = 9'h000;
        bus.instr_valid = 1'b0;
        bus.acc         = 8'h00;
        bus.wb_ready    = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_alu_en", 32'(bus.alu_en), 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_alu_x", 32'(bus.alu_x), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_wb_data", 32'(bus.wb_data), 32'd0);
        check("rst_bypass", 32'(bus.bypass_valid), 32'd0);
        check("rst_timeout", 32'(bus.wb_timeout), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD rs=0: 3C + 05 = 41 into r
        run_alu(9'h182, 8'h3C, 8'h05, 1'b1, 8'h41);
        // SUB rs=1: 05 - 07 = FE into s; r still holds 41
        run_alu(9'h19D, 8'h05, 8'h07, 1'b1, 8'hFE);

        // Stall: ADD 01 + 01 = 02, wb_ready low for 20 HOLD cycles
        run_alu(9'h181, 8'h01, 8'h01, 1'b0, 8'h02);
        for (int h = 0; h < 20; h++) begin
            check("hold_valid", 32'(bus.wb_valid), 32'd1);
            check("hold_data", 32'(bus.wb_data), 32'h02);
            check("hold_ready", 32'(bus.instr_ready), 32'd0);
            check($sformatf("hold_timeout_h%0d", h), 32'(bus.wb_timeout), (h == 15) ? 32'd1 : 32'd0);
            if (h == 19) bus.wb_ready = 1'b1;
            @(negedge clk);
        end
        check("rel_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rel_ready", 32'(bus.instr_ready), 32'd1);
        check("rel_timeout", 32'(bus.wb_timeout), 32'd0);

        // Non-ALU bypass
        bus.instr       = 9'h0A5;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("byp_valid", 32'(bus.bypass_valid), 32'd1);
        check("byp_instr", 32'(bus.bypass_instr), 32'hA5);
        check("byp_alu_en", 32'(bus.alu_en), 32'd0);
        check("byp_ready", 32'(bus.instr_ready), 32'd1);
        check("byp_alu_op", 32'(bus.alu_op), 32'd8);
        check("byp_alu_x", 32'(bus.alu_x), 32'h01);
        @(negedge clk);
        check("byp_pulse_end", 32'(bus.bypass_valid), 32'd0);
        check("byp_alu_en2", 32'(bus.alu_en), 32'd0);

        // Reset during CAPTURE of an EOR
        rf[3]           = 8'h0F;
        bus.acc         = 8'hF0;
        bus.instr       = 9'h133;
        bus.instr_valid = 1'b1;
        bus.wb_ready    = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("eor_alu_en", 32'(bus.alu_en), 32'd1);
        @(negedge clk);
        check("eor_cap_alu_en", 32'(bus.alu_en), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_ready", 32'(bus.instr_ready), 32'd1);
        check("mrst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("mrst_alu_en", 32'(bus.alu_en), 32'd0);
        check("mrst_alu_x", 32'(bus.alu_x), 32'd0);
        check("mrst_alu_y", 32'(bus.alu_y), 32'd0);
        check("mrst_alu_op", 32'(bus.alu_op), 32'd0);
        check("mrst_wb_data", 32'(bus.wb_data), 32'd0);
        check("mrst_wb_dest", 32'(bus.wb_dest), 32'd0);
        bus.instr = 9'h000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mrst_no_wb", 32'(bus.wb_valid), 32'd0);
            check("mrst_no_en", 32'(bus.alu_en), 32'd0);
        end

`ifdef ALU_ISSUE_FLAGS_EN
        // EQL8 of equal operands -> 1, not zero
        run_alu(9'h1A4, 8'h5A, 8'h5A, 1'b1, 8'h01);
        check("flg_eql_zero", 32'(bus.zero_flag), 32'd0);
        check("flg_eql_neg", 32'(bus.neg_flag), 32'd0);
        // AMP F0 & 0F -> 0
        run_alu(9'h106, 8'hF0, 8'h0F, 1'b1, 8'h00);
        check("flg_amp_zero", 32'(bus.zero_flag), 32'd1);
        check("flg_amp_neg", 32'(bus.neg_flag), 32'd0);
        // ADD 80 + 00 -> 80, negative
        run_alu(9'h187, 8'h80, 8'h00, 1'b1, 8'h80);
        check("flg_add_zero", 32'(bus.zero_flag), 32'd0);
        check("flg_add_neg", 32'(bus.neg_flag), 32'd1);
        // Bypass leaves flags alone
        bus.instr       = 9'h000;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("flg_byp_zero", 32'(bus.zero_flag), 32'd0);
        check("flg_byp_neg", 32'(bus.neg_flag), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue-side controller for the 8-bit ALU datapath of the 9-bit CPU.
- Accepts 9-bit ALU-class instructions from fetch over a valid/ready handshake.
- For each instruction it:
  - reads the operand register,
  - drives the ALU control inputs (x, y, math op, enable, r/s select) for exactly one cycle,
  - captures the ALU result from the selected r/s output,
  - presents the result to register-file writeback over a valid/ready handshake.
- Non-ALU instructions are forwarded untouched on a bypass strobe.

Parameters:
- NREG, 8, number of operand registers addressable by instr[2:0] (fixed 8; present for package consistency)
- HOLD_MAX, 15, stall cycles tolerated in HOLD before wb_timeout pulses

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- instr  input  9  instruction word from fetch
- instr_valid  input  1  instr is valid
- instr_ready  output  1  issuer can accept instr this cycle
- acc  input  8  accumulator value; source of ALU x
- rd_addr  output  3  operand register read address (instr[2:0])
- rd_data  input  8  register-file read data; combinational, same cycle as rd_addr
- alu_x  output  8  ALU x operand
- alu_y  output  8  ALU y operand
- alu_op  output  4  math enum value
- alu_en  output  1  ALU enable
- alu_rs  output  1  ALU destination: 0 = r, 1 = s
- r_in  input  8  ALU r_out
- s_in  input  8  ALU s_out
- wb_data  output  8  captured result
- wb_dest  output  1  copy of alu_rs for the result
- wb_valid  output  1  wb_data is valid
- wb_ready  input  1  register file accepts wb_data
- bypass_valid  output  1  one-cycle pulse for a non-ALU instruction
- bypass_instr  output  8  instr[7:0] of the bypassed instruction
- wb_timeout  output  1  one-cycle pulse when the HOLD stall exceeds HOLD_MAX

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous and active-high on reset; it has priority over all other logic.
- Instruction format:
  - instr[8] = 1: ALU class.
  - instr[7:4]: math op. Encoding: AMP=0, LOR, FLP, EOR, RSC, LSC, ROL, ROR, ADD, SUB, EQL8, EQL5, REVx, REVy, PARx, PARy=15.
  - instr[3]: rs.
  - instr[2:0]: y register index.
- Reset values:
  - State = IDLE.
  - instr_ready = 1.
  - alu_en = 0, alu_rs = 0, alu_op = 0.
  - alu_x = 0, alu_y = 0, rd_addr = 0.
  - wb_valid = 0, wb_data = 0, wb_dest = 0.
  - bypass_valid = 0, bypass_instr = 0, wb_timeout = 0.
  - Hold counter = 0.
- States IDLE, ISSUE, CAPTURE, HOLD:
  - IDLE: instr_ready = 1. rd_addr tracks instr[2:0] combinationally.
    - On instr_valid with instr[8] = 1: register op, rs, acc and rd_data into alu_x/alu_y; go to ISSUE.
    - On instr_valid with instr[8] = 0: pulse bypass_valid next cycle with bypass_instr = instr[7:0]; stay in IDLE.
  - ISSUE: alu_en = 1 for exactly this cycle; alu_x, alu_y, alu_op and alu_rs are stable. Go to CAPTURE.
  - CAPTURE: alu_en = 0. Register wb_data = (rs ? s_in : r_in) and wb_dest = rs. Assert wb_valid from the next cycle; go to HOLD.
  - HOLD: wb_valid = 1; wb_data and wb_dest are held stable.
    - On wb_ready: deassert wb_valid next cycle and return to IDLE.
    - Otherwise: increment the hold counter (saturating). Pulse wb_timeout once when the counter reaches HOLD_MAX; remain in HOLD.
- Timing:
  - Accept at cycle 0 → alu_en high in cycle 1 → wb_valid high from cycle 3.
  - With wb_ready held high, a new accept is possible in cycle 4 (one ALU instruction per 4 cycles).
- instr_ready is low in every state except IDLE.
- alu_x, alu_y, alu_op and alu_rs keep their last values outside ISSUE; the ALU holds its result until the next enable.
- A non-ALU instruction never touches the ALU outputs.
- Reset mid-operation: asserting reset in any state returns to IDLE next cycle with all reset values. There is no writeback of the in-flight result; no partial alu_en pulse is emitted.
- Op values are 4 bits, so every value is legal; there is no illegal-op path.

Optional Feature:
- Macro ALU_ISSUE_FLAGS_EN.
- When defined:
  - Adds outputs zero_flag and neg_flag (1 bit each), registered in CAPTURE as (result == 0) and result[7].
  - Both reset to 0.
  - Both are held until the next CAPTURE.
  - Bypassed instructions do not update them.
- When undefined: the ports and logic are absent.

Decomposition:
- Shared package instr_pack holds:
  - the math enum (4-bit values above);
  - field-position constants OPC_ALU_BIT = 8, OPC_MATH_MSB = 7, OPC_MATH_LSB = 4, OPC_RS_BIT = 3;
  - the issue_state_t enum {IDLE, ISSUE, CAPTURE, HOLD}.
- One sub-module, issue_decode: combinational split of instr into is_alu, op, rs and raddr, reused by later fetch logic.

Test Plan:
- ADD, rs = 0, acc = 8'h3C, rd_data = 8'h05, ALU model attached, wb_ready = 1 → alu_en high only in cycle 1 with alu_op = ADD; wb_valid in cycle 3 with wb_data = 8'h41, wb_dest = 0; instr_ready high again in cycle 4.
- SUB, rs = 1, acc = 8'h05, rd_data = 8'h07 → wb_data = 8'hFE, wb_dest = 1, taken from s_in; r_in ignored.
- wb_ready held low for 20 cycles after wb_valid → wb_data stable; instr_ready = 0; wb_timeout pulses exactly once, 15 cycles into HOLD; release → IDLE next cycle.
- instr = 9'h0A5 (non-ALU) → bypass_valid one-cycle pulse with bypass_instr = 8'hA5; alu_en stays 0; instr_ready stays 1.
- reset asserted in the CAPTURE cycle of an EOR → next cycle IDLE, wb_valid = 0, alu_en = 0, all outputs at reset values; no writeback observed.
- With ALU_ISSUE_FLAGS_EN: EQL8 of equal operands → wb_data = 1, zero_flag = 0; then AMP 8'hF0 & 8'h0F → zero_flag = 1, neg_flag = 0.
